pwm_duty_decoder: RTL and testbench
===================================

// Module: pwm_duty_decoder
// PURPOSE
//  Receive side of the LED PWM link: samples a single-bit PWM waveform and recovers the
//  brightness word that produced it (high-cycle count per PWM period). Sits after the pin
//  or loopback of the PWM generator; used for brightness readback and closed-loop checks.
//  Handles the degenerate 0%/100% duty cases via timeout, and flags off-nominal periods.
// PARAMETERS
//  WIDTH    5    brightness output width; must hold PERIOD (2**WIDTH > PERIOD)
//  PERIOD   16   nominal PWM period in clk cycles
//  TIMEOUT  32   cycles without a rising edge before declaring the line stuck (> PERIOD)
// PORTS
//  clk         in   1      system clock; all logic on posedge
//  reset       in   1      asynchronous, active-low reset
//  pwm_in      in   1      PWM waveform, asynchronous to clk
//  brightness  out  WIDTH  last decoded high-cycle count, 0..PERIOD
//  valid       out  1      one-cycle strobe: brightness updated this cycle
//  locked      out  1      at least one full period (or stuck decision) seen since reset
//  period_err  out  1      last measured period != PERIOD (sticky until next good period)
// BEHAVIOUR
//  - Reset (reset==0, async): brightness=0, valid=0, locked=0, period_err=0, state SYNC,
//    counters 0, synchronizer flops 0. Reset mid-measure discards the partial period.
//  - pwm_in passes a 2-flop synchronizer, then a rise detector (s & ~s_d). All latencies
//    below count from the synchronized sample; pin-to-sample adds 2 cycles.
//  - Counters: per_cnt (cycles since last rise), hi_cnt (high samples since last rise);
//    width $clog2(TIMEOUT+1), both saturate at TIMEOUT, never wrap.
//  - States:
//    SYNC:    wait for first rise; no valid. On rise: per_cnt=1, hi_cnt=1 -> MEASURE.
//             If per_cnt reaches TIMEOUT -> STUCK (line was never toggling).
//    MEASURE: each cycle per_cnt++, hi_cnt += s. On rise: next cycle valid=1,
//             brightness=hi_cnt (clamped to PERIOD), period_err=(per_cnt!=PERIOD),
//             locked=1; counters restart at 1 (rise sample counts as high).
//             If per_cnt reaches TIMEOUT with no rise -> STUCK.
//    STUCK:   emit valid every PERIOD cycles (first on entry), brightness=PERIOD if s==1
//             else 0; period_err=0; locked=1. On rise -> MEASURE with counters=1, no
//             valid for the partial period ended by that rise.
//  - Simultaneous rise and timeout on same cycle: rise wins (normal MEASURE decode).
//  - valid is never asserted on two consecutive cycles; brightness holds between strobes.
//  - A period containing multiple high pulses (glitch) decodes as total high samples in
//    that rise-to-rise span; period_err reflects the shortened span.
// STRUCTURE
//  - pwm_pkg: state enum {SYNC, MEASURE, STUCK} and a shared clog2-based counter-width
//    helper, also used by the generator and stepper.
//  - One sub-module: sync_rise_detect (2-flop synchronizer + rise pulse, async active-low
//    reset). FSM, counters and output registers live in this module.
// TESTING (PERIOD=16, TIMEOUT=32, WIDTH=5; golden-monitor compare on brightness/valid)
//  1. PWM with 5 high / 11 low repeated -> after first full period, valid every 16 cycles,
//     brightness=5, period_err=0, locked=1.
//  2. Drive a 0..15..0 triangle brightness ramp (one step per 16-cycle period) into the PWM
//     generator and loop back -> decoded sequence equals the ramp, delayed one period.
//  3. pwm_in held 0 from reset -> no valid for 32 cycles, then valid with brightness=0
//     every 16 cycles; held 1 -> same cadence with brightness=16.
//  4. Period 20 cycles, 7 high -> brightness=7, period_err=1; return to 16 -> period_err=0.
//  5. Assert reset mid-period (duty 9/16) -> outputs 0 immediately; after release, no valid
//     until the second synchronized rise, then brightness=9.
//  6. 1-cycle glitch high inside a low phase (duty 4/16) -> two short periods flagged
//     period_err=1; brightness=4 again once glitches stop.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the LED PWM link (generator, stepper, decoder).
package pwm_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } dec_state_e;

    // Bits needed for a counter that must hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer for an asynchronous input, plus a one-cycle rising-edge pulse.
module sync_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic s_o,
    output logic rise_o
);

    logic meta_q;
    logic s_q;
    logic s_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            s_q     <= 1'b0;
            s_dly_q <= 1'b0;
        end else begin
            meta_q  <= d_i;
            s_q     <= meta_q;
            s_dly_q <= s_q;
        end
    end

    assign s_o    = s_q;
    assign rise_o = s_q & ~s_dly_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers the brightness word (high samples per rise-to-rise span) from a sampled PWM line,
// with timeout handling for stuck-at-0/1 lines and an off-nominal period flag.
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned PERIOD  = 16,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] brightness,
    output logic             valid,
    output logic             locked,
    output logic             period_err
);

    localparam int unsigned      CW     = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]    ONE_C  = CW'(1);
    localparam logic [CW-1:0]    PER_C  = CW'(PERIOD);
    localparam logic [CW-1:0]    TO_C   = CW'(TIMEOUT);
    localparam logic [WIDTH-1:0] FULL_B = WIDTH'(PERIOD);

    logic s;
    logic rise;

    sync_rise_detect u_sync (
        .clk    (clk),
        .rst_n  (reset),
        .d_i    (pwm_in),
        .s_o    (s),
        .rise_o (rise)
    );

    dec_state_e       state_q,  state_d;
    logic [CW-1:0]    per_q,    per_d;
    logic [CW-1:0]    hi_q,     hi_d;
    logic [WIDTH-1:0] bright_q, bright_d;
    logic             valid_q,  valid_d;
    logic             locked_q, locked_d;
    logic             perr_q,   perr_d;

    logic [CW-1:0]    per_inc;
    logic [CW-1:0]    hi_inc;
    logic [WIDTH-1:0] hi_clamped;
    logic [WIDTH-1:0] level_b;

    // Counters saturate at TIMEOUT so a long span can never alias to a short one.
    assign per_inc    = (per_q == TO_C) ? per_q : per_q + ONE_C;
    assign hi_inc     = (s && (hi_q != TO_C)) ? hi_q + ONE_C : hi_q;
    assign hi_clamped = (hi_q > PER_C) ? FULL_B : WIDTH'(hi_q);
    assign level_b    = s ? FULL_B : '0;

    always_comb begin
        state_d  = state_q;
        per_d    = per_q;
        hi_d     = hi_q;
        bright_d = bright_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        perr_d   = perr_q;

        unique case (state_q)
            SYNC: begin
                if (rise) begin
                    state_d = MEASURE;
                    per_d   = ONE_C;
                    hi_d    = ONE_C;
                end else if (per_q == TO_C) begin
                    state_d  = STUCK;
                    valid_d  = 1'b1;
                    bright_d = level_b;
                    perr_d   = 1'b0;
                    locked_d = 1'b1;
                    per_d    = ONE_C;
                    hi_d     = '0;
                end else begin
                    per_d = per_inc;
                end
            end

            MEASURE: begin
                // A rise on the same sample as the timeout still decodes normally.
                if (rise) begin
                    valid_d  = 1'b1;
                    bright_d = hi_clamped;
                    perr_d   = (per_q != PER_C);
                    locked_d = 1'b1;
                    per_d    = ONE_C;
                    hi_d     = ONE_C;
                end else if (per_q == TO_C) begin
                    state_d  = STUCK;
                    valid_d  = 1'b1;
                    bright_d = level_b;
                    perr_d   = 1'b0;
                    locked_d = 1'b1;
                    per_d    = ONE_C;
                    hi_d     = '0;
                end else begin
                    per_d = per_inc;
                    hi_d  = hi_inc;
                end
            end

            STUCK: begin
                // per_q doubles as the strobe cadence counter while the line is static.
                if (rise) begin
                    state_d = MEASURE;
                    per_d   = ONE_C;
                    hi_d    = ONE_C;
                end else if (per_q == PER_C) begin
                    valid_d  = 1'b1;
                    bright_d = level_b;
                    perr_d   = 1'b0;
                    locked_d = 1'b1;
                    per_d    = ONE_C;
                end else begin
                    per_d = per_inc;
                end
            end

            default: begin
                state_d = SYNC;
                per_d   = '0;
                hi_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= SYNC;
            per_q    <= '0;
            hi_q     <= '0;
            bright_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            bright_q <= bright_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            perr_q   <= perr_d;
        end
    end

    assign brightness = bright_q;
    assign valid      = valid_q;
    assign locked     = locked_q;
    assign period_err = perr_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: PWM segments queue their expected decode when the
// closing rise is driven; a negedge monitor pops and compares on every valid strobe.
module tb_pwm_duty_decoder;

    localparam int unsigned W = 5;
    localparam int unsigned P = 16;
    localparam int unsigned T = 32;

    typedef struct packed {
        logic [W-1:0] b;
        logic         e;
    } exp_t;

    logic         clk    = 1'b0;
    logic         reset  = 1'b0;
    logic         pwm_in = 1'b0;
    logic [W-1:0] brightness;
    logic         valid;
    logic         locked;
    logic         period_err;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   pend = 1'b0;
    int   pend_hi = 0;
    int   pend_len = 0;
    bit   valid_prev = 1'b0;

    always #5 clk = ~clk;

    pwm_duty_decoder #(.WIDTH(W), .PERIOD(P), .TIMEOUT(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .brightness (brightness),
        .valid      (valid),
        .locked     (locked),
        .period_err (period_err)
    );

    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid) begin
            checks++;
            if (valid_prev) begin
                errors++;
                $display("FAIL valid_spacing: got valid on consecutive cycles, want isolated strobe");
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got brightness=%0d err=%0d, want no strobe",
                         brightness, period_err);
            end else begin
                e = sb.pop_front();
                checks++;
                if (brightness !== e.b) begin
                    errors++;
                    $display("FAIL decode_brightness: got %0d want %0d", brightness, e.b);
                end
                checks++;
                if (period_err !== e.e) begin
                    errors++;
                    $display("FAIL decode_period_err: got %0d want %0d (brightness %0d)",
                             period_err, e.e, e.b);
                end
            end
        end
        valid_prev = valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic level);
        reset  = 1'b0;
        pwm_in = level;
        sb.delete();
        pend   = 1'b0;
        tick(3);
        reset  = 1'b1;
    endtask

    // Drive hi cycles high then lo cycles low; a rise closes the previous rise-to-rise span.
    task automatic seg(input int hi, input int lo);
        exp_t x;
        if (hi > 0) begin
            if (pend) begin
                x.b = W'((pend_hi > int'(P)) ? int'(P) : pend_hi);
                x.e = (pend_len != int'(P));
                sb.push_back(x);
            end
            pend     = 1'b1;
            pend_hi  = hi;
            pend_len = hi + lo;
            pwm_in   = 1'b1;
            tick(hi);
        end else if (pend) begin
            pend_len += lo;
        end
        pwm_in = 1'b0;
        if (lo > 0) tick(lo);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 8 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d decodes outstanding, want 0", name, sb.size());
        end
    endtask

    task automatic check_flags(input string name, input logic [W-1:0] b, input logic l,
                               input logic pe);
        checks++;
        if (brightness !== b) begin
            errors++;
            $display("FAIL %s_brightness: got %0d want %0d", name, brightness, b);
        end
        checks++;
        if (locked !== l) begin
            errors++;
            $display("FAIL %s_locked: got %0d want %0d", name, locked, l);
        end
        checks++;
        if (period_err !== pe) begin
            errors++;
            $display("FAIL %s_period_err: got %0d want %0d", name, period_err, pe);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick(3);
        check_flags("reset", '0, 1'b0, 1'b0);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0d want 0", valid);
        end
    endtask

    task automatic test_steady;
        do_reset(1'b0);
        seg(5, 11);
        check_flags("steady_prelock", '0, 1'b0, 1'b0);
        repeat (5) seg(5, 11);
        seg(1, 3);
        drain("steady");
        check_flags("steady", 5'd5, 1'b1, 1'b0);
    endtask

    task automatic test_ramp;
        do_reset(1'b0);
        for (int v = 1; v <= 15; v++) seg(v, int'(P) - v);
        for (int v = 14; v >= 1; v--) seg(v, int'(P) - v);
        seg(1, 3);
        drain("ramp");
        check_flags("ramp_end", 5'd1, 1'b1, 1'b0);
    endtask

    task automatic test_stuck(input logic level);
        exp_t x;
        int   seen = 0;
        int   first = 0;
        int   prev = 0;
        do_reset(level);
        x.b = level ? W'(P) : '0;
        x.e = 1'b0;
        repeat (4) sb.push_back(x);
        for (int c = 1; c <= 150 && seen < 4; c++) begin
            tick(1);
            if (valid) begin
                if (seen == 0) begin
                    first = c;
                    checks++;
                    if (c <= int'(T) || c > int'(T) + 8) begin
                        errors++;
                        $display("FAIL stuck%0d_first: got strobe at cycle %0d, want %0d..%0d",
                                 level, c, T + 1, T + 8);
                    end
                end else begin
                    checks++;
                    if (c - prev != int'(P)) begin
                        errors++;
                        $display("FAIL stuck%0d_cadence: got interval %0d want %0d",
                                 level, c - prev, P);
                    end
                end
                prev = c;
                seen++;
            end
        end
        checks++;
        if (seen < 4) begin
            errors++;
            $display("FAIL stuck%0d_timeout: got %0d strobes want 4 (first at %0d)",
                     level, seen, first);
        end
        drain(level ? "stuck1" : "stuck0");
        check_flags(level ? "stuck1" : "stuck0", level ? W'(P) : '0, 1'b1, 1'b0);
        if (!level) begin
            repeat (3) seg(3, 13);
            seg(1, 3);
            drain("recover");
            check_flags("recover", 5'd3, 1'b1, 1'b0);
        end
    endtask

    task automatic test_period_err;
        do_reset(1'b0);
        repeat (3) seg(7, 13);
        seg(5, 11);
        drain("per20");
        check_flags("per20", 5'd7, 1'b1, 1'b1);
        seg(5, 11);
        seg(3, 29);
        seg(5, 11);
        seg(1, 3);
        drain("per_back");
        check_flags("per_back", 5'd5, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid;
        do_reset(1'b0);
        repeat (3) seg(9, 7);
        seg(9, 3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midrst_pre: got %0d outstanding want 0", sb.size());
        end
        reset = 1'b0;
        #1;
        check_flags("midrst_async", '0, 1'b0, 1'b0);
        sb.delete();
        pend = 1'b0;
        tick(3);
        reset = 1'b1;
        seg(9, 7);
        check_flags("midrst_first", '0, 1'b0, 1'b0);
        repeat (2) seg(9, 7);
        seg(1, 3);
        drain("midrst");
        check_flags("midrst", 5'd9, 1'b1, 1'b0);
    endtask

    task automatic test_glitch;
        do_reset(1'b0);
        repeat (2) seg(4, 12);
        repeat (2) begin
            seg(4, 5);
            seg(1, 6);
        end
        seg(4, 12);
        drain("glitch_mid");
        check_flags("glitch_mid", 5'd1, 1'b1, 1'b1);
        seg(4, 12);
        seg(1, 3);
        drain("glitch");
        check_flags("glitch", 5'd4, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_steady();
        test_ramp();
        test_stuck(1'b1);
        test_stuck(1'b0);
        test_period_err();
        test_reset_mid();
        test_glitch();
        reset = 1'b0;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, want bench end");
        $fatal(1);
    end

endmodule
